// File: rtl/wavetable_pkg.sv
// Constants and state encoding shared by the wavetable reader and loader.
package wavetable_pkg;

    localparam int VOICES         = 4;
    localparam int WTB_RAM_SIZE   = 61;
    localparam int WTB_RAM_SIZE_W = 6;
    localparam int PHASE_W        = 8;
    localparam int WFM_W          = 8;

    localparam logic [7:0] SILENCE = 8'h80;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_WTB = 3'd1,
        RD_WFM = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Morph positions past the last table entry read the last entry.
    function automatic logic [WTB_RAM_SIZE_W-1:0] clamp_morph(input logic [WTB_RAM_SIZE_W-1:0] pos);
        if (pos > WTB_RAM_SIZE_W'(WTB_RAM_SIZE - 1))
            return WTB_RAM_SIZE_W'(WTB_RAM_SIZE - 1);
        return pos;
    endfunction

endpackage

// File: rtl/wavetable_interp.sv
// Crossfade datapath: sample = a + floor((b - a) * factor / 256), registered.
module wavetable_interp
    import wavetable_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mute,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [COEF_W-1:0] factor,
    output logic [DATA_W-1:0] sample
);

    localparam int PW = DATA_W + COEF_W + 1;

    // The floor shift keeps the result between a and b, so no saturation is needed.
    function automatic logic [DATA_W-1:0] crossfade(input logic [DATA_W-1:0] fa,
                                                    input logic [DATA_W-1:0] fb,
                                                    input logic [COEF_W-1:0] ff);
        logic signed [DATA_W:0] diff;
        logic signed [COEF_W:0] coef;
        logic signed [PW-1:0]   prod;
        logic signed [PW-1:0]   sum;
        diff = $signed({1'b0, fb}) - $signed({1'b0, fa});
        coef = $signed({1'b0, ff});
        prod = PW'(diff) * PW'(coef);
        sum  = PW'($signed({1'b0, fa})) + (prod >>> COEF_W);
        return DATA_W'(sum);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sample <= DATA_W'(SILENCE);
        else if (en)
            sample <= mute ? DATA_W'(SILENCE) : crossfade(a, b, factor);
    end

endmodule

// File: rtl/wavetable_reader.sv
// Per-tick walk over voices 0..3: wavetable RAM lookup, waveform ROM reads, crossfade.
module wavetable_reader
    import wavetable_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tick,
    input  logic [VOICES*WTB_RAM_SIZE_W-1:0]   morph_pos,
    input  logic [VOICES*PHASE_W-1:0]          phase,
    input  logic                               loader_idle,
    input  logic [1:0]                         loader_voice,
    output logic                               wtb_ram_re,
    output logic [1:0]                         wtb_ram_sel,
    output logic [WTB_RAM_SIZE_W-1:0]          wtb_ram_addr_r,
    input  logic [WFM_W-1:0]                   wtb_ram_wfm_l_r,
    input  logic [WFM_W-1:0]                   wtb_ram_wfm_r_r,
    input  logic [7:0]                         wtb_ram_factor_r,
    output logic                               wfm_rom_re,
    output logic [WFM_W+PHASE_W-1:0]           wfm_rom_addr_a,
    output logic [WFM_W+PHASE_W-1:0]           wfm_rom_addr_b,
    input  logic [7:0]                         wfm_rom_data_a,
    input  logic [7:0]                         wfm_rom_data_b,
    output logic [7:0]                         sample,
    output logic [1:0]                         sample_voice,
    output logic                               sample_valid,
    output logic                               frame_done,
    output logic                               busy,
    output logic                               overrun
);

    state_t                      state, state_nxt;
    logic [1:0]                  voice;
    logic                        mute_p1;
    logic [7:0]                  factor_p1;
    logic                        mute_now;
    logic [WTB_RAM_SIZE_W-1:0]   morph_v;
    logic [PHASE_W-1:0]          phase_v;

    always_comb begin
        morph_v  = morph_pos[WTB_RAM_SIZE_W*voice +: WTB_RAM_SIZE_W];
        phase_v  = phase[PHASE_W*voice +: PHASE_W];
        mute_now = !loader_idle && (loader_voice == voice);
    end

    always_comb begin
        state_nxt      = state;
        wtb_ram_re     = 1'b0;
        wtb_ram_sel    = voice;
        wtb_ram_addr_r = '0;
        wfm_rom_re     = 1'b0;
        wfm_rom_addr_a = '0;
        wfm_rom_addr_b = '0;
        case (state)
            IDLE: begin
                if (tick)
                    state_nxt = RD_WTB;
            end
            RD_WTB: begin
                wtb_ram_re     = !mute_now;
                wtb_ram_addr_r = clamp_morph(morph_v);
                state_nxt      = RD_WFM;
            end
            // RAM data arrives this cycle and feeds the ROM addresses directly.
            RD_WFM: begin
                wfm_rom_re     = !mute_p1;
                wfm_rom_addr_a = {wtb_ram_wfm_l_r, phase_v};
                wfm_rom_addr_b = {wtb_ram_wfm_r_r, phase_v};
                state_nxt      = CALC;
            end
            CALC: begin
                state_nxt = (voice == 2'd3) ? DONE : RD_WTB;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            voice        <= '0;
            mute_p1      <= 1'b0;
            factor_p1    <= '0;
            sample_valid <= 1'b0;
            sample_voice <= '0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (state == IDLE && tick)
                voice <= '0;
            else if (state == CALC && voice != 2'd3)
                voice <= voice + 2'd1;
            if (state == RD_WTB)
                mute_p1 <= mute_now;
            if (state == RD_WFM)
                factor_p1 <= wtb_ram_factor_r;
            sample_valid <= (state == CALC);
            frame_done   <= (state == CALC) && (voice == 2'd3);
            if (state == CALC)
                sample_voice <= voice;
            if (tick && state != IDLE)
                overrun <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

    // ROM data for this voice is valid during CALC; the result lands in sample next cycle.
    wavetable_interp #(
        .DATA_W (8),
        .COEF_W (8)
    ) u_interp (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state == CALC),
        .mute   (mute_p1),
        .a      (wfm_rom_data_a),
        .b      (wfm_rom_data_b),
        .factor (factor_p1),
        .sample (sample)
    );

endmodule

// File: tb/tb_wavetable_reader.sv
// Bench for wavetable_reader: RAM/ROM models, vector table and a sample scoreboard.
module tb_wavetable_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [23:0] morph_pos = '0;
    logic [31:0] phase = '0;
    logic        loader_idle = 1'b1;
    logic [1:0]  loader_voice = '0;
    logic        wtb_ram_re;
    logic [1:0]  wtb_ram_sel;
    logic [5:0]  wtb_ram_addr_r;
    logic [7:0]  wtb_ram_wfm_l_r = '0;
    logic [7:0]  wtb_ram_wfm_r_r = '0;
    logic [7:0]  wtb_ram_factor_r = '0;
    logic        wfm_rom_re;
    logic [15:0] wfm_rom_addr_a;
    logic [15:0] wfm_rom_addr_b;
    logic [7:0]  wfm_rom_data_a = '0;
    logic [7:0]  wfm_rom_data_b = '0;
    logic [7:0]  sample;
    logic [1:0]  sample_voice;
    logic        sample_valid;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    wavetable_reader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tick             (tick),
        .morph_pos        (morph_pos),
        .phase            (phase),
        .loader_idle      (loader_idle),
        .loader_voice     (loader_voice),
        .wtb_ram_re       (wtb_ram_re),
        .wtb_ram_sel      (wtb_ram_sel),
        .wtb_ram_addr_r   (wtb_ram_addr_r),
        .wtb_ram_wfm_l_r  (wtb_ram_wfm_l_r),
        .wtb_ram_wfm_r_r  (wtb_ram_wfm_r_r),
        .wtb_ram_factor_r (wtb_ram_factor_r),
        .wfm_rom_re       (wfm_rom_re),
        .wfm_rom_addr_a   (wfm_rom_addr_a),
        .wfm_rom_addr_b   (wfm_rom_addr_b),
        .wfm_rom_data_a   (wfm_rom_data_a),
        .wfm_rom_data_b   (wfm_rom_data_b),
        .sample           (sample),
        .sample_voice     (sample_voice),
        .sample_valid     (sample_valid),
        .frame_done       (frame_done),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
        logic [5:0] morph;
        logic [7:0] ph;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[12];

    typedef struct {
        logic [1:0] v;
        logic [7:0] s;
        int         c;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] cur_a[4];
    logic [7:0] cur_b[4];
    logic [7:0] cur_f[4];

    int total = 0;
    int bad = 0;
    int frame_t = -100;
    int ram_re_n = 0;
    int rom_re_n = 0;
    int done_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] clamp_ref(input logic [5:0] m);
        return (m > 6'd60) ? 6'd60 : m;
    endfunction

    // Wavetable RAM: the index encodes the lane so the ROM model can verify addressing.
    always @(posedge clk) begin
        if (wtb_ram_re) begin
            wtb_ram_wfm_l_r  <= {4'h1, 2'b00, wtb_ram_sel};
            wtb_ram_wfm_r_r  <= {4'h2, 2'b00, wtb_ram_sel};
            wtb_ram_factor_r <= cur_f[wtb_ram_sel];
        end
    end

    always @(posedge clk) begin
        if (wfm_rom_re) begin
            wfm_rom_data_a <= (wfm_rom_addr_a[15:10] == 6'b000100 &&
                               wfm_rom_addr_a[7:0] == phase[8*wfm_rom_addr_a[9:8] +: 8])
                              ? cur_a[wfm_rom_addr_a[9:8]] : 8'hEE;
            wfm_rom_data_b <= (wfm_rom_addr_b[15:10] == 6'b001000 &&
                               wfm_rom_addr_b[7:0] == phase[8*wfm_rom_addr_b[9:8] +: 8])
                              ? cur_b[wfm_rom_addr_b[9:8]] : 8'hEE;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wtb_ram_re) begin
                ram_re_n++;
                check("ram_re_slot", (cyc - frame_t - 1) % 3, 0);
                check("ram_sel", wtb_ram_sel, (cyc - frame_t - 1) / 3);
                check("ram_addr", wtb_ram_addr_r, clamp_ref(morph_pos[6*wtb_ram_sel +: 6]));
            end
            if (wfm_rom_re)
                rom_re_n++;
            if (frame_done) begin
                done_n++;
                check("done_with_v3", {sample_valid, sample_voice}, 3'b111);
            end
            if (sample_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sample: got voice=%0d sample=%0h want none", sample_voice, sample);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("sample_voice", sample_voice, e.v);
                    check("sample_value", sample, e.s);
                    check("sample_cycle", cyc, e.c);
                end
            end
        end
    end

    task automatic run_frame(input int base, input bit mute_en, input logic [1:0] mv,
                             input int extra_at, input int rst_at);
        int t0, r0, o0, d0;
        bit aborted;
        logic [7:0] v0_exp;
        for (int v = 0; v < 4; v++) begin
            cur_a[v] = tbl[base+v].a;
            cur_b[v] = tbl[base+v].b;
            cur_f[v] = tbl[base+v].f;
            morph_pos[6*v +: 6] = tbl[base+v].morph;
            phase[8*v +: 8] = tbl[base+v].ph;
        end
        loader_idle = !mute_en;
        loader_voice = mv;
        @(posedge clk);
        #1;
        t0 = cyc;
        frame_t = t0;
        for (int v = 0; v < 4; v++) begin
            exp_t e;
            e.v = 2'(v);
            e.s = (mute_en && mv == 2'(v)) ? 8'h80 : tbl[base+v].exp;
            e.c = t0 + 4 + 3*v;
            sbq.push_back(e);
        end
        v0_exp = (mute_en && mv == 2'd0) ? 8'h80 : tbl[base].exp;
        r0 = ram_re_n;
        o0 = rom_re_n;
        d0 = done_n;
        aborted = 1'b0;
        tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            tick = (extra_at > 0 && k == extra_at);
            if (rst_at > 0 && k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_sample", sample, 8'h80);
                check("abort_valid", sample_valid, 0);
                check("abort_done", frame_done, 0);
                check("abort_overrun", overrun, 0);
                check("abort_ram_re", wtb_ram_re, 0);
                aborted = 1'b1;
                break;
            end
            if (k == 5) check("sample_hold", sample, v0_exp);
            if (k == 13) check("busy_at_13", busy, 1);
            if (k == 14) check("idle_at_14", busy, 0);
        end
        tick = 1'b0;
        if (aborted) begin
            check("abort_ram_reads", ram_re_n - r0, 3);
            check("abort_no_done", done_n - d0, 0);
            sbq.delete();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
        end else begin
            check("all_samples_seen", sbq.size(), 0);
            check("ram_read_count", ram_re_n - r0, mute_en ? 3 : 4);
            check("rom_read_count", rom_re_n - o0, mute_en ? 3 : 4);
            check("frame_done_count", done_n - d0, 1);
            sbq.delete();
        end
    endtask

    initial begin
        tbl[0]  = '{a:8'h40, b:8'h99, f:8'h00, morph:6'd5,  ph:8'h11, exp:8'h40};
        tbl[1]  = '{a:8'h00, b:8'hFF, f:8'h80, morph:6'd63, ph:8'h22, exp:8'h7F};
        tbl[2]  = '{a:8'hFF, b:8'h00, f:8'h80, morph:6'd60, ph:8'h33, exp:8'h7F};
        tbl[3]  = '{a:8'h10, b:8'h10, f:8'hFF, morph:6'd61, ph:8'h44, exp:8'h10};
        tbl[4]  = '{a:8'h00, b:8'hFF, f:8'hFF, morph:6'd0,  ph:8'h00, exp:8'hFE};
        tbl[5]  = '{a:8'hFF, b:8'h00, f:8'hFF, morph:6'd62, ph:8'hFF, exp:8'h00};
        tbl[6]  = '{a:8'h20, b:8'h60, f:8'h40, morph:6'd33, ph:8'h5A, exp:8'h30};
        tbl[7]  = '{a:8'h60, b:8'h20, f:8'h40, morph:6'd59, ph:8'hA5, exp:8'h50};
        tbl[8]  = '{a:8'h80, b:8'h81, f:8'h01, morph:6'd1,  ph:8'h01, exp:8'h80};
        tbl[9]  = '{a:8'h81, b:8'h80, f:8'h01, morph:6'd30, ph:8'h80, exp:8'h80};
        tbl[10] = '{a:8'h00, b:8'h01, f:8'hFF, morph:6'd45, ph:8'h7F, exp:8'h00};
        tbl[11] = '{a:8'hC8, b:8'h37, f:8'hA0, morph:6'd12, ph:8'hC3, exp:8'h6D};

        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", sample, 8'h80);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_done", frame_done, 0);
        check("rst_ram_re", wtb_ram_re, 0);
        check("rst_rom_re", wfm_rom_re, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_frame(0, 1'b0, 2'd0, 0, 0);
        run_frame(4, 1'b0, 2'd0, 0, 0);
        run_frame(8, 1'b0, 2'd0, 0, 0);
        check("no_overrun", overrun, 0);

        run_frame(0, 1'b1, 2'd2, 0, 0);
        check("mute_no_overrun", overrun, 0);

        run_frame(4, 1'b0, 2'd0, 6, 0);
        check("overrun_set", overrun, 1);

        run_frame(8, 1'b0, 2'd0, 0, 8);
        check("after_rst_overrun", overrun, 0);
        run_frame(8, 1'b0, 2'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
